// File: rtl/bus_cycle.sv
// Bus cycle sequencer for the CFT external data bus.
// Turns microcode memory/IO read/write requests into a timed strobe sequence
// (SETUP, STROBE with wait states, END) and stalls the microcode through nhold.
// Every output is a flop whose next value is decoded from the next state, so
// the strobes change on the same edge as the state and have no input-to-output
// combinational path.
`timescale 1ns/1ps

module bus_cycle #(
   parameter int MIN_WS  = 2,
   parameter int TO_BITS = 8,
   parameter int TIMEOUT = 255
) (
   input  logic clk1,
   input  logic nreset,
   input  logic nmem_req,
   input  logic nio_req,
   input  logic nwrite_req,
   input  logic nws,
   output logic nmem,
   output logic nio,
   output logic nr,
   output logic nwen,
   output logic nhold,
   output logic nbuserr,
   output logic busy
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_STROBE = 2'd2,
      ST_END    = 2'd3
   } state_t;

   localparam logic [3:0]         MIN_WS_C  = 4'(MIN_WS);
   localparam logic [TO_BITS-1:0] TIMEOUT_C = TO_BITS'(TIMEOUT);

   state_t             state_r, state_s;
   logic               io_r, io_s;        // 1 = I/O cycle, 0 = memory cycle
   logic               rd_r, rd_s;        // 1 = read cycle, 0 = write cycle
   logic [3:0]         wait_r, wait_s;
   logic [TO_BITS-1:0] to_r, to_s, to_inc_s;
   logic               sync1_r, sync2_r;
   logic               err_s;
   logic               active_s;

   logic nmem_r, nio_r, nr_r, nwen_r, nhold_r, nbuserr_r, busy_r;
   logic nmem_s, nio_s, nr_s, nwen_s, nhold_s, nbuserr_s, busy_s;

   // Two-flop synchroniser for the asynchronous device wait request.
   always_ff @(posedge clk1 or negedge nreset) begin
      if (!nreset) begin
         sync1_r <= 1'b1;
         sync2_r <= 1'b1;
      end else begin
         sync1_r <= nws;
         sync2_r <= sync1_r;
      end
   end

   // Next-state, counter and bus-error decode for the cycle FSM.
   always_comb begin
      state_s  = state_r;
      io_s     = io_r;
      rd_s     = rd_r;
      wait_s   = wait_r;
      to_s     = to_r;
      err_s    = 1'b0;
      to_inc_s = to_r + TO_BITS'(1);
      case (state_r)
         ST_IDLE: begin
            if (!nmem_req && !nio_req) begin
               // Both spaces at once is illegal: flag it and start nothing.
               err_s   = 1'b1;
               state_s = ST_IDLE;
            end else if (!nmem_req) begin
               io_s    = 1'b0;
               rd_s    = nwrite_req;
               state_s = ST_SETUP;
            end else if (!nio_req) begin
               io_s    = 1'b1;
               rd_s    = nwrite_req;
               state_s = ST_SETUP;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_SETUP: begin
            wait_s  = MIN_WS_C;
            to_s    = '0;
            state_s = ST_STROBE;
         end
         ST_STROBE: begin
            to_s = to_inc_s;
            if (wait_r != 4'd0) begin
               wait_s = wait_r - 4'd1;
            end else begin
               wait_s = wait_r;
            end
            // Timeout wins over a normal exit landing on the same cycle.
            if (to_inc_s == TIMEOUT_C) begin
               err_s   = 1'b1;
               state_s = ST_END;
            end else if ((wait_r == 4'd0) && sync2_r) begin
               state_s = ST_END;
            end else begin
               state_s = ST_STROBE;
            end
         end
         ST_END: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Output decode from the next state, so registered strobes track the state.
   always_comb begin
      active_s  = (state_s != ST_IDLE);
      nmem_s    = ~(active_s & ~io_s);
      nio_s     = ~(active_s & io_s);
      nr_s      = ~(active_s & rd_s);
      nwen_s    = ~((state_s == ST_STROBE) & ~rd_s);
      nhold_s   = ~((state_s == ST_SETUP) | (state_s == ST_STROBE));
      nbuserr_s = ~err_s;
      busy_s    = active_s;
   end

   // State, cycle attributes and counters.
   always_ff @(posedge clk1 or negedge nreset) begin
      if (!nreset) begin
         state_r <= ST_IDLE;
         io_r    <= 1'b0;
         rd_r    <= 1'b1;
         wait_r  <= 4'd0;
         to_r    <= '0;
      end else begin
         state_r <= state_s;
         io_r    <= io_s;
         rd_r    <= rd_s;
         wait_r  <= wait_s;
         to_r    <= to_s;
      end
   end

   // Registered bus outputs; reset releases every strobe at once.
   always_ff @(posedge clk1 or negedge nreset) begin
      if (!nreset) begin
         nmem_r    <= 1'b1;
         nio_r     <= 1'b1;
         nr_r      <= 1'b1;
         nwen_r    <= 1'b1;
         nhold_r   <= 1'b1;
         nbuserr_r <= 1'b1;
         busy_r    <= 1'b0;
      end else begin
         nmem_r    <= nmem_s;
         nio_r     <= nio_s;
         nr_r      <= nr_s;
         nwen_r    <= nwen_s;
         nhold_r   <= nhold_s;
         nbuserr_r <= nbuserr_s;
         busy_r    <= busy_s;
      end
   end

   assign nmem    = nmem_r;
   assign nio     = nio_r;
   assign nr      = nr_r;
   assign nwen    = nwen_r;
   assign nhold   = nhold_r;
   assign nbuserr = nbuserr_r;
   assign busy    = busy_r;

endmodule

// File: tb/tb_bus_cycle.sv
// Self-checking bench for bus_cycle: a per-cycle vector table for the basic
// read/write/illegal cycles, plus hand sequences for back-to-back reads,
// device wait, timeout (second instance with TIMEOUT=10) and reset mid-write.
`timescale 1ns/1ps

module tb_bus_cycle;

   logic clk1 = 1'b0;
   logic nreset = 1'b0;

   logic a_nmem_req, a_nio_req, a_nwrite_req, a_nws;
   logic a_nmem, a_nio, a_nr, a_nwen, a_nhold, a_nbuserr, a_busy;
   logic b_nmem_req, b_nio_req, b_nwrite_req, b_nws;
   logic b_nmem, b_nio, b_nr, b_nwen, b_nhold, b_nbuserr, b_busy;
   logic [6:0] a_out, b_out;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic [3:0] in;    // {nmem_req, nio_req, nwrite_req, nws}
      logic [6:0] exp;   // {nmem, nio, nr, nwen, nhold, nbuserr, busy}
      string      name;
   } vec_t;

   vec_t vq[$];

   localparam logic [6:0] O_IDLE  = 7'b1111110;
   localparam logic [6:0] O_ILL   = 7'b1111100;
   localparam logic [6:0] O_MR_SS = 7'b0101011;
   localparam logic [6:0] O_MR_E  = 7'b0101111;
   localparam logic [6:0] O_IW_S  = 7'b1011011;
   localparam logic [6:0] O_IW_T  = 7'b1010011;
   localparam logic [6:0] O_IW_E  = 7'b1011111;
   localparam logic [6:0] O_MW_S  = 7'b0111011;
   localparam logic [6:0] O_MW_T  = 7'b0110011;
   localparam logic [6:0] O_MW_E  = 7'b0111111;

   bus_cycle u_a (
      .clk1(clk1), .nreset(nreset),
      .nmem_req(a_nmem_req), .nio_req(a_nio_req), .nwrite_req(a_nwrite_req), .nws(a_nws),
      .nmem(a_nmem), .nio(a_nio), .nr(a_nr), .nwen(a_nwen),
      .nhold(a_nhold), .nbuserr(a_nbuserr), .busy(a_busy)
   );

   bus_cycle #(.MIN_WS(2), .TO_BITS(8), .TIMEOUT(10)) u_b (
      .clk1(clk1), .nreset(nreset),
      .nmem_req(b_nmem_req), .nio_req(b_nio_req), .nwrite_req(b_nwrite_req), .nws(b_nws),
      .nmem(b_nmem), .nio(b_nio), .nr(b_nr), .nwen(b_nwen),
      .nhold(b_nhold), .nbuserr(b_nbuserr), .busy(b_busy)
   );

   assign a_out = {a_nmem, a_nio, a_nr, a_nwen, a_nhold, a_nbuserr, a_busy};
   assign b_out = {b_nmem, b_nio, b_nr, b_nwen, b_nhold, b_nbuserr, b_busy};

   // 10 ns clock.
   always #5 clk1 = ~clk1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic add_vec(input logic [3:0] i, input logic [6:0] e, input string n);
      vec_t v;
      v.in   = i;
      v.exp  = e;
      v.name = n;
      vq.push_back(v);
   endtask

   task automatic set_a(input logic [3:0] v);
      {a_nmem_req, a_nio_req, a_nwrite_req, a_nws} = v;
   endtask

   task automatic set_b(input logic [3:0] v);
      {b_nmem_req, b_nio_req, b_nwrite_req, b_nws} = v;
   endtask

   // Main stimulus.
   initial begin
      int nwen_lo, nio_lo, last_nwen, last_nio, nmem_hi_seen;
      int hold_lo, err_lo, err_idx, mem_lo;

      set_a(4'b1111);
      set_b(4'b1111);

      // Reset state.
      @(negedge clk1);
      @(negedge clk1);
      check("reset_a", {25'd0, a_out}, {25'd0, O_IDLE});
      check("reset_b", {25'd0, b_out}, {25'd0, O_IDLE});
      nreset = 1'b1;

      // Per-cycle table: memory read, I/O write, illegal, memory write.
      add_vec(4'b1111, O_IDLE,  "idle");
      add_vec(4'b0111, O_MR_SS, "mr_setup");
      add_vec(4'b1111, O_MR_SS, "mr_strobe1");
      add_vec(4'b1111, O_MR_SS, "mr_strobe2");
      add_vec(4'b1111, O_MR_SS, "mr_strobe3");
      add_vec(4'b1111, O_MR_E,  "mr_end");
      add_vec(4'b1111, O_IDLE,  "mr_idle");
      add_vec(4'b1001, O_IW_S,  "iw_setup");
      add_vec(4'b1111, O_IW_T,  "iw_strobe1");
      add_vec(4'b1111, O_IW_T,  "iw_strobe2");
      add_vec(4'b1111, O_IW_T,  "iw_strobe3");
      add_vec(4'b1111, O_IW_E,  "iw_end");
      add_vec(4'b1111, O_IDLE,  "iw_idle");
      add_vec(4'b0011, O_ILL,   "illegal");
      add_vec(4'b1111, O_IDLE,  "illegal_after");
      add_vec(4'b0101, O_MW_S,  "mw_setup");
      add_vec(4'b1111, O_MW_T,  "mw_strobe1");
      add_vec(4'b1011, O_MW_T,  "mw_strobe2_ignreq");
      add_vec(4'b1111, O_MW_T,  "mw_strobe3");
      add_vec(4'b1111, O_MW_E,  "mw_end");
      add_vec(4'b1111, O_IDLE,  "mw_idle");

      foreach (vq[i]) begin
         set_a(vq[i].in);
         @(negedge clk1);
         check(vq[i].name, {25'd0, a_out}, {25'd0, vq[i].exp});
      end

      // Back-to-back reads: 5 strobe cycles, 1 IDLE, repeat.
      set_a(4'b0111);
      for (int k = 0; k < 12; k++) begin
         @(negedge clk1);
         check("b2b_nmem", {31'd0, a_nmem}, (k % 6 == 5) ? 32'd1 : 32'd0);
         check("b2b_busy", {31'd0, a_busy}, (k % 6 == 5) ? 32'd0 : 32'd1);
      end
      set_a(4'b1111);
      @(negedge clk1);
      check("b2b_release", {25'd0, a_out}, {25'd0, O_IDLE});

      // I/O write with nws low for 6 edges starting at the request edge.
      set_a(4'b1000);
      nwen_lo = 0; nio_lo = 0; last_nwen = -1; last_nio = -1; nmem_hi_seen = 1;
      for (int i = 0; i < 14; i++) begin
         @(negedge clk1);
         if (!a_nwen) begin nwen_lo++; last_nwen = i; end
         if (!a_nio)  begin nio_lo++;  last_nio  = i; end
         if (!a_nmem) nmem_hi_seen = 0;
         if (i == 0) set_a(4'b1100);
         if (i == 5) set_a(4'b1101);
      end
      check("ws_nwen_cycles", nwen_lo, 32'd7);
      check("ws_nio_cycles",  nio_lo,  32'd9);
      check("ws_nwen_last",   last_nwen, 32'd7);
      check("ws_nio_last",    last_nio,  32'd8);
      check("ws_nmem_high",   nmem_hi_seen, 32'd1);
      check("ws_idle", {25'd0, a_out}, {25'd0, O_IDLE});
      set_a(4'b1111);

      // Timeout on the TIMEOUT=10 instance with nws stuck low.
      set_b(4'b0110);
      hold_lo = 0; err_lo = 0; err_idx = -1; mem_lo = 0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk1);
         if (!b_nhold)   hold_lo++;
         if (!b_nmem)    mem_lo++;
         if (!b_nbuserr) begin
            err_lo++;
            err_idx = i;
            check("to_end_busy",  {31'd0, b_busy},  32'd1);
            check("to_end_nhold", {31'd0, b_nhold}, 32'd1);
         end
         if (i == 0) set_b(4'b1110);
      end
      check("to_nhold_cycles", hold_lo, 32'd11);
      check("to_nmem_cycles",  mem_lo,  32'd12);
      check("to_err_pulses",   err_lo,  32'd1);
      check("to_err_index",    err_idx, 32'd11);
      check("to_idle", {25'd0, b_out}, {25'd0, O_IDLE});
      set_b(4'b1111);

      // Reset asserted in the middle of a write strobe.
      set_a(4'b1001);
      @(negedge clk1);
      set_a(4'b1111);
      @(negedge clk1);
      check("rst_pre_nwen", {31'd0, a_nwen}, 32'd0);
      #2 nreset = 1'b0;
      #1 check("rst_async", {25'd0, a_out}, {25'd0, O_IDLE});
      @(negedge clk1);
      nreset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk1);
         check("rst_no_resume", {25'd0, a_out}, {25'd0, O_IDLE});
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
